// File: rtl/mips_datapath_memory_stage_pkg.sv
// Memory-stage shared definitions.
// - Memory_Control_T: control bundle handed to the byte-addressed memory.
// - mem_state_e: stage FSM encoding (RUN / FAULT).
// - mem_req_t / mem_rsp_t: contents of the A (request) and B (result) registers.
// - be_size(): access width in bytes for a ByteEnable code.
package mips_datapath_memory_stage_pkg;

  typedef enum logic [1:0] {BE_NONE, BE_BYTE, BE_HALF, BE_WORD} byte_en_e;
  typedef enum logic       {EXT_UNSIGNED, EXT_SIGNED}            byte_ext_e;

  typedef struct packed {
    logic      WriteEnable;
    byte_en_e  ByteEnable;
    byte_ext_e ByteExtend;
  } Memory_Control_T;

  typedef enum logic {ST_RUN, ST_FAULT} mem_state_e;

  typedef struct packed {
    Memory_Control_T ctrl;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [4:0]      rd;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
  } mem_rsp_t;

  function automatic logic [2:0] be_size(byte_en_e be);
    case (be)
      BE_BYTE: be_size = 3'd1;
      BE_HALF: be_size = 3'd2;
      BE_WORD: be_size = 3'd4;
      default: be_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mips_datapath_memory_stage_if.sv
// Bus bundle for the Memory stage: Execute-side request handshake, the
// memory port, Writeback-side result handshake and the pipeline flush.
// - master: the stage itself.
// - slave : the surrounding datapath (Execute, memory, Writeback, hazard unit).
interface mips_datapath_memory_stage_if
  import mips_datapath_memory_stage_pkg::*;
#(parameter int ADDR_L = 64);
  localparam int ADDR_W = $clog2(ADDR_L);

  logic              in_valid;
  logic              in_ready;
  Memory_Control_T   in_control;
  logic [31:0]       in_addr;
  logic [31:0]       in_data;
  logic [4:0]        in_rd;
  Memory_Control_T   mem_control;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [31:0]       mem_out;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [4:0]        out_rd;
  logic              out_exc;
  logic              flush;

  modport master (
    input  in_valid, in_control, in_addr, in_data, in_rd, mem_out, out_ready, flush,
    output in_ready, mem_control, mem_addr, mem_data, out_valid, out_data, out_rd, out_exc
  );

  modport slave (
    output in_valid, in_control, in_addr, in_data, in_rd, mem_out, out_ready, flush,
    input  in_ready, mem_control, mem_addr, mem_data, out_valid, out_data, out_rd, out_exc
  );
endinterface

// File: rtl/mips_datapath_memory_stage_align.sv
// Combinational alignment / range check for one memory access.
// - be_i    : access width (None never faults).
// - addr_i  : byte address.
// - fault_o : misaligned Half/Word, or last byte at/after ADDR_L.
module mips_datapath_memory_align
  import mips_datapath_memory_stage_pkg::*;
#(parameter int ADDR_L = 64) (
  input  byte_en_e    be_i,
  input  logic [31:0] addr_i,
  output logic        fault_o
);
  logic [32:0] last;
  logic        over;

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign last = {1'b0, addr_i} + {30'd0, be_size(be_i)} - 33'd1;
  assign over = (last >= 33'(ADDR_L));

  always_comb begin
    fault_o = 1'b0;
    case (be_i)
      BE_BYTE: fault_o = over;
      BE_HALF: fault_o = addr_i[0] | over;
      BE_WORD: fault_o = (|addr_i[1:0]) | over;
      default: fault_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_datapath_memory_stage.sv
// MIPS datapath Memory stage: two-register pipeline (A drives the memory,
// B holds the result for Writeback) with valid/ready on both sides.
// - Clock / Reset : clock, asynchronous active-low reset.
// - bus (master)  : request in, memory port out, result out, flush in.
// A faulting access is turned into a no-op with out_exc=1 and the stage
// stops accepting until flushed.
module mips_datapath_memory_stage
  import mips_datapath_memory_stage_pkg::*;
#(parameter int ADDR_L = 64) (
  input logic                           Clock,
  input logic                           Reset,
  mips_datapath_memory_stage_if.master  bus
);
  localparam int ADDR_W = $clog2(ADDR_L);

  mem_state_e      state_q, state_d;
  logic            a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  mem_req_t        a_q, a_d;
  mem_rsp_t        b_q, b_d;
  logic            a_adv, accept, fault;
  Memory_Control_T mctl;

  mips_datapath_memory_align #(.ADDR_L(ADDR_L)) u_align (
    .be_i    (a_q.ctrl.ByteEnable),
    .addr_i  (a_q.addr),
    .fault_o (fault)
  );

  assign a_adv        = a_vld_q & (~b_vld_q | bus.out_ready);
  assign bus.in_ready = (state_q == ST_RUN) & (~a_vld_q | a_adv) & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  // The write strobe is only raised in the advancing cycle, so a store
  // stalled in A writes once, when it finally leaves.
  always_comb begin
    mctl = '{WriteEnable: 1'b0, ByteEnable: BE_NONE, ByteExtend: EXT_UNSIGNED};
    if (a_vld_q) begin
      mctl.ByteExtend = a_q.ctrl.ByteExtend;
      if (!fault) mctl.ByteEnable = a_q.ctrl.ByteEnable;
      mctl.WriteEnable = a_q.ctrl.WriteEnable & (a_q.ctrl.ByteEnable != BE_NONE)
                       & a_adv & ~fault & ~bus.flush;
    end
  end

  assign bus.mem_control = mctl;
  assign bus.mem_addr    = a_q.addr[ADDR_W-1:0];
  assign bus.mem_data    = a_q.data;
  assign bus.out_valid   = b_vld_q;
  assign bus.out_data    = b_q.data;
  assign bus.out_rd      = b_q.rd;
  assign bus.out_exc     = b_q.exc;

  always_comb begin
    state_d = state_q;
    a_vld_d = a_vld_q;
    a_d     = a_q;
    b_vld_d = b_vld_q;
    b_d     = b_q;
    if (bus.flush) begin
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
      state_d = ST_RUN;
    end else begin
      if (a_adv) begin
        b_vld_d  = 1'b1;
        b_d.data = (a_q.ctrl.WriteEnable || fault || a_q.ctrl.ByteEnable == BE_NONE)
                   ? 32'd0 : bus.mem_out;
        b_d.rd   = a_q.rd;
        b_d.exc  = fault;
        a_vld_d  = 1'b0;
        if (fault) state_d = ST_FAULT;
      end else if (bus.out_ready) begin
        b_vld_d = 1'b0;
      end
      if (accept) begin
        a_vld_d = 1'b1;
        a_d     = '{ctrl: bus.in_control, addr: bus.in_addr, data: bus.in_data, rd: bus.in_rd};
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end
endmodule

// File: tb/tb_mips_datapath_memory_stage.sv
// Directed bench for the Memory stage with a little-endian 64-byte memory
// model hanging off the mem_* port.
module tb_mips_datapath_memory_stage;
  import mips_datapath_memory_stage_pkg::*;

  localparam int ADDR_L = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_datapath_memory_stage_if #(.ADDR_L(ADDR_L)) bus ();

  mips_datapath_memory_stage #(.ADDR_L(ADDR_L)) u_dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // memory model
  logic [7:0] mem [ADDR_L] = '{default: 8'h00};
  int wcnt = 0;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0] rdata;

  assign a0 = bus.mem_addr;
  assign a1 = a0 + 6'd1;
  assign a2 = a0 + 6'd2;
  assign a3 = a0 + 6'd3;

  always_comb begin
    rdata = 32'd0;
    case (bus.mem_control.ByteEnable)
      BE_BYTE: rdata = (bus.mem_control.ByteExtend == EXT_SIGNED)
                       ? {{24{mem[a0][7]}}, mem[a0]} : {24'd0, mem[a0]};
      BE_HALF: rdata = (bus.mem_control.ByteExtend == EXT_SIGNED)
                       ? {{16{mem[a1][7]}}, mem[a1], mem[a0]} : {16'd0, mem[a1], mem[a0]};
      BE_WORD: rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      default: rdata = 32'd0;
    endcase
  end
  assign bus.mem_out = rdata;

  always @(posedge clk) begin
    if (bus.mem_control.WriteEnable) begin
      wcnt <= wcnt + 1;
      case (bus.mem_control.ByteEnable)
        BE_BYTE: mem[a0] <= bus.mem_data[7:0];
        BE_HALF: begin mem[a0] <= bus.mem_data[7:0]; mem[a1] <= bus.mem_data[15:8]; end
        BE_WORD: begin
          mem[a0] <= bus.mem_data[7:0];   mem[a1] <= bus.mem_data[15:8];
          mem[a2] <= bus.mem_data[23:16]; mem[a3] <= bus.mem_data[31:24];
        end
        default: ;
      endcase
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic Memory_Control_T mc(input logic we, input byte_en_e be, input byte_ext_e ext);
    mc = '{WriteEnable: we, ByteEnable: be, ByteExtend: ext};
  endfunction

  task automatic send(input Memory_Control_T c, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_control = c;
    bus.in_addr    = addr;
    bus.in_data    = data;
    bus.in_rd      = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] word;

  initial begin
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_control = mc(1'b0, BE_NONE, EXT_UNSIGNED);
    bus.in_addr    = '0;
    bus.in_data    = '0;
    bus.in_rd      = '0;
    bus.out_ready  = 1'b1;
    bus.flush      = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data, 32'd0);
    chk("rst_out_rd",    32'(bus.out_rd), 32'd0);
    chk("rst_out_exc",   32'(bus.out_exc), 32'd0);
    chk("rst_we",        32'(bus.mem_control.WriteEnable), 32'd0);
    chk("rst_be",        32'(bus.mem_control.ByteEnable), 32'(BE_NONE));
    #10 rst_n = 1'b1;

    // word store then word load, back to back
    send(mc(1'b1, BE_WORD, EXT_UNSIGNED), 32'h10, 32'hDEADBEEF, 5'd5);
    chk("sw_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("sw_we",   32'(bus.mem_control.WriteEnable), 32'd1);
    chk("sw_addr", 32'(bus.mem_addr), 32'h10);
    chk("sw_data", bus.mem_data, 32'hDEADBEEF);
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h10, 32'h0, 5'd7);
    tick();
    chk("sw_out_valid", 32'(bus.out_valid), 32'd1);
    chk("sw_out_data",  bus.out_data, 32'd0);
    chk("sw_out_rd",    32'(bus.out_rd), 32'd5);
    chk("sw_wcnt",      32'(wcnt), 32'd1);
    chk("lw_we",        32'(bus.mem_control.WriteEnable), 32'd0);
    idle();
    tick();
    chk("lw_valid", 32'(bus.out_valid), 32'd1);
    chk("lw_data",  bus.out_data, 32'hDEADBEEF);
    chk("lw_rd",    32'(bus.out_rd), 32'd7);
    tick();
    chk("lw_drain", 32'(bus.out_valid), 32'd0);

    // byte / half loads
    send(mc(1'b0, BE_BYTE, EXT_SIGNED), 32'h10, 32'h0, 5'd1);
    tick();
    send(mc(1'b0, BE_BYTE, EXT_UNSIGNED), 32'h10, 32'h0, 5'd2);
    tick();
    idle();
    chk("lb_data", bus.out_data, 32'hFFFFFFEF);
    tick();
    chk("lbu_data", bus.out_data, 32'h000000EF);
    chk("lbu_rd",   32'(bus.out_rd), 32'd2);
    send(mc(1'b0, BE_HALF, EXT_UNSIGNED), 32'h12, 32'h0, 5'd3);
    tick();
    idle();
    tick();
    chk("lhu_data", bus.out_data, 32'h0000DEAD);

    // ByteEnable None with WriteEnable: traverses, touches nothing
    send(mc(1'b1, BE_NONE, EXT_UNSIGNED), 32'h10, 32'h55555555, 5'd4);
    tick();
    idle();
    chk("none_we", 32'(bus.mem_control.WriteEnable), 32'd0);
    tick();
    chk("none_valid", 32'(bus.out_valid), 32'd1);
    chk("none_data",  bus.out_data, 32'd0);
    chk("none_exc",   32'(bus.out_exc), 32'd0);
    chk("none_wcnt",  32'(wcnt), 32'd1);
    tick();

    // backpressure: each store writes exactly once
    bus.out_ready = 1'b0;
    send(mc(1'b1, BE_WORD, EXT_UNSIGNED), 32'h20, 32'h12345678, 5'd8);
    tick();
    chk("bp_we1", 32'(bus.mem_control.WriteEnable), 32'd1);
    send(mc(1'b1, BE_WORD, EXT_UNSIGNED), 32'h24, 32'hCAFEF00D, 5'd9);
    chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    chk("bp_rdy_full", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_we_stall", 32'(bus.mem_control.WriteEnable), 32'd0);
      chk("bp_rd_stable", 32'(bus.out_rd), 32'd8);
      chk("bp_rdy_stall", 32'(bus.in_ready), 32'd0);
      tick();
    end
    chk("bp_wcnt", 32'(wcnt), 32'd2);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_we2", 32'(bus.mem_control.WriteEnable), 32'd1);
    tick();
    chk("bp_rd2",   32'(bus.out_rd), 32'd9);
    chk("bp_wcnt2", 32'(wcnt), 32'd3);
    tick();
    word = {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]};
    chk("bp_mem1", word, 32'h12345678);
    word = {mem[8'h27], mem[8'h26], mem[8'h25], mem[8'h24]};
    chk("bp_mem2", word, 32'hCAFEF00D);

    // misaligned word load: fault, stall until flush
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h12, 32'h0, 5'd10);
    tick();
    idle();
    chk("flt_be", 32'(bus.mem_control.ByteEnable), 32'(BE_NONE));
    tick();
    chk("flt_exc",  32'(bus.out_exc), 32'd1);
    chk("flt_data", bus.out_data, 32'd0);
    chk("flt_rdy",  32'(bus.in_ready), 32'd0);
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h10, 32'h0, 5'd11);
    tick();
    chk("flt_rdy_hold", 32'(bus.in_ready), 32'd0);
    chk("flt_drained",  32'(bus.out_valid), 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("flt_rdy_flush", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flt_rdy_after", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    tick();
    chk("flt_reload_data", bus.out_data, 32'hDEADBEEF);
    chk("flt_reload_rd",   32'(bus.out_rd), 32'd11);
    chk("flt_reload_exc",  32'(bus.out_exc), 32'd0);
    tick();

    // range boundary
    send(mc(1'b0, BE_HALF, EXT_UNSIGNED), 32'h3F, 32'h0, 5'd12);
    tick();
    idle();
    tick();
    chk("h3f_exc", 32'(bus.out_exc), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("h3f_flushed", 32'(bus.out_valid), 32'd0);
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h3C, 32'h0, 5'd13);
    tick();
    idle();
    tick();
    chk("w3c_valid", 32'(bus.out_valid), 32'd1);
    chk("w3c_exc",   32'(bus.out_exc), 32'd0);
    tick();

    // reset in the cycle a store advances
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h10, 32'h0, 5'd15);
    tick();
    send(mc(1'b1, BE_WORD, EXT_UNSIGNED), 32'h30, 32'h11111111, 5'd14);
    tick();
    idle();
    chk("rs_pre_data", bus.out_data, 32'hDEADBEEF);
    chk("rs_pre_we",   32'(bus.mem_control.WriteEnable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_we",        32'(bus.mem_control.WriteEnable), 32'd0);
    chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rs_out_data",  bus.out_data, 32'd0);
    chk("rs_out_rd",    32'(bus.out_rd), 32'd0);
    tick();
    chk("rs_wcnt", 32'(wcnt), 32'd3);
    word = {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]};
    chk("rs_mem", word, 32'd0);
    rst_n = 1'b1;
    send(mc(1'b0, BE_WORD, EXT_UNSIGNED), 32'h10, 32'h0, 5'd16);
    chk("rs_rdy", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    tick();
    chk("rs_reload", bus.out_data, 32'hDEADBEEF);
    chk("rs_reload_rd", 32'(bus.out_rd), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
